// File: rtl/ripple_mw_add_if.sv
// Request/result bundle for the multi-word ripple add/subtract sequencer.
// The master drives operands and start; the slave returns busy/done and the result.
interface ripple_mw_add_if #(
    parameter int W     = 4,
    parameter int WORDS = 4
);
    localparam int N = W * WORDS;

    logic         start;
    logic         sub;
    logic         cin;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         busy;
    logic         done;
    logic [N-1:0] S;
    logic         C;

    modport master (
        output start, sub, cin, A, B,
        input  busy, done, S, C
    );

    modport slave (
        input  start, sub, cin, A, B,
        output busy, done, S, C
    );
endinterface

// File: rtl/ripple_mw_add_ctrl.sv
// Wide add/subtract built from one W-bit ripple chunk adder reused over WORDS cycles,
// with the inter-chunk carry held in a register between cycles.
//
// state | meaning
// IDLE  | waiting for start; S/C hold the last result
// RUN   | one chunk per cycle, low chunk first; busy=1
// DONE  | done=1 for one cycle; a new start may be accepted here
module ripple_mw_add_ctrl #(
    parameter int W     = 4,
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    ripple_mw_add_if.slave        bus
);
    localparam int N    = W * WORDS;
    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [N-1:0]      a_q, a_d;
    logic [N-1:0]      b_q, b_d;
    logic [N-1:0]      s_q, s_d;
    logic              carry_q, carry_d;
    logic              c_q, c_d;

    logic [W-1:0]      a_ch;
    logic [W-1:0]      b_ch;
    logic [W-1:0]      sum_ch;
    logic              cy;

    // Operand chunk select for the current index.
    always_comb begin
        a_ch = '0;
        b_ch = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (idx_q == IDXW'(i)) begin
                a_ch = a_q[i*W +: W];
                b_ch = b_q[i*W +: W];
            end
        end
    end

    // The single shared W-bit ripple-carry adder.
    always_comb begin
        logic rc;
        rc     = carry_q;
        sum_ch = '0;
        for (int j = 0; j < W; j++) begin
            sum_ch[j] = a_ch[j] ^ b_ch[j] ^ rc;
            rc        = (a_ch[j] & b_ch[j]) | (rc & (a_ch[j] ^ b_ch[j]));
        end
        cy = rc;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        carry_d = carry_q;
        c_d     = c_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    // Subtract is A + ~B + 1, so the inversion and the +1 happen at accept.
                    a_d     = bus.A;
                    b_d     = bus.sub ? ~bus.B : bus.B;
                    carry_d = bus.sub ? 1'b1 : bus.cin;
                    idx_d   = '0;
                    s_d     = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                for (int i = 0; i < WORDS; i++) begin
                    if (idx_q == IDXW'(i)) begin
                        s_d[i*W +: W] = sum_ch;
                    end
                end
                carry_d = cy;
                if (idx_q == IDXW'(WORDS - 1)) begin
                    c_d     = cy;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            c_q     <= c_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.S    = s_q;
    assign bus.C    = c_q;
endmodule
